maxpool2d_param_engine: RTL and testbench
=========================================

Name: maxpool2d_param_engine

Overview:
Parametrised 2-D pooling engine for the CNN accelerator datapath, successor to the fixed 2x2/stride-2/64-channel max-pool stage.
- Loads a CH x IN_H x IN_W signed feature map through a write port.
- Computes max or average pooling with window POOL_K and stride STRIDE, with optional fused ReLU.
- Stores the pooled map in an internal buffer, readable by address once done is high.

Parameters:
DATA_W, 4, signed element width (input and output)
CH, 64, channel count
IN_H, 16, input height
IN_W, 16, input width
POOL_K, 2, window size; legal values 2 or 4 (avg mode requires power of two)
STRIDE, 2, window stride; 1..POOL_K
ADDR_W, 32, width of in_addr and read_addr
Derived: OUT_H=(IN_H-POOL_K)/STRIDE+1, OUT_W=(IN_W-POOL_K)/STRIDE+1, IN_N=CH*IN_H*IN_W, OUT_N=CH*OUT_H*OUT_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a pooling pass when idle
mode  in  2  bit0: 0=max, 1=avg; bit1: fused ReLU enable; sampled on accepted start
in_we  in  1  input buffer write enable
in_addr  in  ADDR_W  input address = ch*IN_H*IN_W + row*IN_W + col
in_data  in  DATA_W  signed input element
read_addr  in  ADDR_W  output address = ch*OUT_H*OUT_W + r*OUT_W + c
read_data  out  DATA_W  signed pooled element, registered
busy  out  1  high while a pass is running
done  out  1  high from pass completion until the next accepted start

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; busy=0, done=0, read_data=0; all counters and the accumulator cleared.
  - Buffers are not cleared.
  - Reset mid-pass aborts the pass; output buffer contents are undefined until a new pass completes.
- Input writes:
  - Accepted only when busy=0 and in_addr < IN_N; one element per cycle.
  - Writes while busy, or with out-of-range addresses, are dropped.
- Read port:
  - read_data registers out_buf[read_addr] one cycle after read_addr is presented, in any state.
  - read_addr >= OUT_N returns 0.
  - Reads during a pass return the current buffer contents; they are not guaranteed stable.
- start:
  - Accepted only in IDLE or DONE. Acceptance captures mode, clears done, and enters INIT.
  - start while busy is ignored.
- FSM states:
  - IDLE: wait for start.
  - INIT: load the accumulator (max: most-negative value, -2^(DATA_W-1); avg: 0); reset kr, kc to 0. One cycle.
  - ACC: issue one input-buffer read per cycle at (ch, r*STRIDE+kr, c*STRIDE+kc), kc fastest. The buffer read is synchronous (1-cycle latency). Fold each returned data into the accumulator. POOL_K^2 issue cycles.
  - DRAIN: absorb the last returned element. One cycle.
  - WRITE: form the result and write out_buf[ch, r, c]. Advance c, then r, then ch. Next state is INIT, or DONE after the last window.
  - DONE: done=1, busy=0; hold until start (go to INIT) or reset.
- Per-window cost is POOL_K^2+3 cycles.
  - busy rises on the clock edge that samples start.
  - done rises exactly OUT_N*(POOL_K^2+3) cycles after that edge.
- Arithmetic:
  - Max: signed compare; keep the larger value.
  - Avg:
    - Signed accumulator of DATA_W+2*log2(POOL_K) bits, no overflow possible.
    - Result = accumulator arithmetic-shifted right by 2*log2(POOL_K), i.e. floor toward -inf.
    - The shifted value always fits DATA_W; truncate to DATA_W.
  - ReLU (mode[1]=1): a negative result is replaced by 0 after pooling.
- Window coordinates never exceed the input; edge rows/columns not covered by any window are ignored.
- Simultaneous start and in_we in IDLE: start is accepted and the write is dropped. busy is already being asserted on that edge.

Test Plan:
- Default params, max, no ReLU; channel c, position (y,x) input = ((c+y+x) mod 16)-8 -> out[0]=max(-8,-7,-7,-6)=-6. Check all 4096 outputs against the model. Check done at exactly 4096*7 cycles after the start edge.
- Avg mode, channel-0 window {-3,-2,-2,-1} -> sum -8 >> 2 = -2. Window {-1,0,0,0} -> -1, confirming floor rounding.
- mode=11 (avg+ReLU) on a window averaging -2 -> 0. mode=10 on a window with max 5 -> 5.
- Start pulse and in_we mid-pass -> no restart, done timing unchanged, write dropped. read_addr=4096 -> read_data=0.
- Assert reset halfway through a pass -> busy/done/read_data=0 immediately. A new start then completes with correct results and nominal latency.
- POOL_K=4, STRIDE=2, CH=2, IN_H=IN_W=8 -> OUT_H=OUT_W=3, OUT_N=18. Max and avg match the model. done at 18*19 cycles after the start edge.

Source files
------------

// File: rtl/maxpool2d_param_engine_if.sv
// maxpool2d_param_engine_if: control, load and read-back bus of the pooling engine
interface maxpool2d_param_engine_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 32
);
    logic                     start;
    logic [1:0]               mode;
    logic                     in_we;
    logic [ADDR_W-1:0]        in_addr;
    logic signed [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0]        read_addr;
    logic signed [DATA_W-1:0] read_data;
    logic                     busy;
    logic                     done;
    modport master (output start, mode, in_we, in_addr, in_data, read_addr, input read_data, busy, done);
    modport slave (input start, mode, in_we, in_addr, in_data, read_addr, output read_data, busy, done);
endinterface

// File: rtl/maxpool2d_param_engine.sv
// maxpool2d_param_engine: parametrised max/avg 2-D pooling over a buffered feature map
module maxpool2d_param_engine #(
    parameter int DATA_W = 4,
    parameter int CH = 64,
    parameter int IN_H = 16,
    parameter int IN_W = 16,
    parameter int POOL_K = 2,
    parameter int STRIDE = 2,
    parameter int ADDR_W = 32
) (
    input logic clk,
    input logic reset,
    maxpool2d_param_engine_if.slave bus
);
    localparam int OUT_H = (IN_H - POOL_K) / STRIDE + 1;
    localparam int OUT_W = (IN_W - POOL_K) / STRIDE + 1;
    localparam int IN_N = CH * IN_H * IN_W;
    localparam int OUT_N = CH * OUT_H * OUT_W;
    localparam int SH = 2 * $clog2(POOL_K);
    localparam int ACC_W = DATA_W + SH;
    localparam int IAW = $clog2(IN_N);
    localparam int OAW = $clog2(OUT_N);
    localparam int CW = $clog2(CH + 1);
    localparam int RW = $clog2(OUT_H + 1);
    localparam int QW = $clog2(OUT_W + 1);
    localparam int KW = $clog2(POOL_K + 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(SH + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
    typedef enum logic [2:0] {IDLE, INIT, ACC, DRAIN, WRITE, DONE} state_t;
    state_t state, nxt;
    logic [1:0] mode_q;
    logic [CW-1:0] ch;
    logic [RW-1:0] r;
    logic [QW-1:0] c;
    logic [KW-1:0] kr, kc;
    logic signed [ACC_W-1:0] acc, elem, fold;
    logic signed [DATA_W-1:0] pooled, res, in_q, rdata;
    logic signed [DATA_W-1:0] in_buf [IN_N];
    logic signed [DATA_W-1:0] out_buf [OUT_N];
    logic busy, rd_vld, start_ok, we_ok, last_k, last_win, last_c, last_r;
    logic [IAW-1:0] rd_idx;
    logic [OAW-1:0] wr_idx;

    assign busy = state != IDLE && state != DONE;
    assign bus.busy = busy;
    assign bus.done = state == DONE;
    assign bus.read_data = rdata;

    // Handshake decode, window addressing and the fold/result datapath
    always_comb begin
        start_ok = bus.start && !busy;
        we_ok = bus.in_we && !busy && !bus.start && bus.in_addr < ADDR_W'(IN_N);
        last_k = kr == KW'(POOL_K - 1) && kc == KW'(POOL_K - 1);
        last_c = c == QW'(OUT_W - 1);
        last_r = r == RW'(OUT_H - 1);
        last_win = ch == CW'(CH - 1) && last_r && last_c;
        rd_idx = IAW'(ch) * IAW'(IN_H * IN_W) + (IAW'(r) * IAW'(STRIDE) + IAW'(kr)) * IAW'(IN_W)
               + IAW'(c) * IAW'(STRIDE) + IAW'(kc);
        wr_idx = OAW'(ch) * OAW'(OUT_H * OUT_W) + OAW'(r) * OAW'(OUT_W) + OAW'(c);
        elem = ACC_W'(in_q);
        fold = mode_q[0] ? acc + elem : (elem > acc ? elem : acc);
        pooled = mode_q[0] ? DATA_W'(acc >>> SH) : DATA_W'(acc);
        res = mode_q[1] && pooled[DATA_W-1] ? '0 : pooled;
    end

    // Next state: each window is INIT, POOL_K^2 ACC issues, DRAIN, WRITE
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = start_ok ? INIT : state;
            INIT: nxt = ACC;
            ACC: nxt = last_k ? DRAIN : ACC;
            DRAIN: nxt = WRITE;
            WRITE: nxt = last_win ? DONE : INIT;
            default: nxt = IDLE;
        endcase
    end

    // Control state, window counters, accumulator and registered read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mode_q <= '0;
            ch <= '0;
            r <= '0;
            c <= '0;
            kr <= '0;
            kc <= '0;
            acc <= '0;
            rd_vld <= 1'b0;
            rdata <= '0;
        end else begin
            state <= nxt;
            rd_vld <= state == ACC;
            rdata <= bus.read_addr < ADDR_W'(OUT_N) ? out_buf[bus.read_addr[OAW-1:0]] : '0;
            if (start_ok) begin
                mode_q <= bus.mode;
                ch <= '0;
                r <= '0;
                c <= '0;
            end
            if (state == INIT) begin
                acc <= mode_q[0] ? '0 : ACC_MIN;
                kr <= '0;
                kc <= '0;
            end
            if (state == ACC) begin
                kc <= kc == KW'(POOL_K - 1) ? '0 : kc + KW'(1);
                if (kc == KW'(POOL_K - 1)) kr <= kr + KW'(1);
            end
            if (rd_vld) acc <= fold;
            if (state == WRITE) begin
                c <= last_c ? '0 : c + QW'(1);
                if (last_c) r <= last_r ? '0 : r + RW'(1);
                if (last_c && last_r) ch <= ch == CW'(CH - 1) ? '0 : ch + CW'(1);
            end
        end
    end

    // Input buffer load port and synchronous window read; result buffer write
    always_ff @(posedge clk) begin
        if (we_ok) in_buf[bus.in_addr[IAW-1:0]] <= bus.in_data;
        in_q <= in_buf[rd_idx];
        if (state == WRITE) out_buf[wr_idx] <= res;
    end
endmodule

// File: tb/tb_maxpool2d_param_engine.sv
// tb_maxpool2d_param_engine: three engine configurations run side by side with a read scoreboard
module tb_maxpool2d_param_engine;
    localparam int NI = 3;
    localparam int KK [NI] = '{2, 4, 2};
    localparam int CC [NI] = '{64, 2, 2};
    localparam int HH [NI] = '{16, 8, 4};
    localparam int ST = 2;

    logic clk = 1'b0;
    logic rst [NI];
    logic start [NI];
    logic [1:0] mode [NI];
    logic in_we [NI];
    logic [31:0] in_addr [NI];
    logic signed [3:0] in_data [NI];
    logic [31:0] read_addr [NI];
    logic signed [3:0] rdat [NI];
    logic busy [NI];
    logic done [NI];
    bit rv [NI];
    bit rv_d [NI];
    int q [NI][$];
    int img [NI][16384];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        maxpool2d_param_engine_if #(.DATA_W(4), .ADDR_W(32)) b ();
        assign b.start = start[g];
        assign b.mode = mode[g];
        assign b.in_we = in_we[g];
        assign b.in_addr = in_addr[g];
        assign b.in_data = in_data[g];
        assign b.read_addr = read_addr[g];
        assign busy[g] = b.busy;
        assign done[g] = b.done;
        assign rdat[g] = b.read_data;
        maxpool2d_param_engine #(
            .DATA_W(4), .CH(CC[g]), .IN_H(HH[g]), .IN_W(HH[g]),
            .POOL_K(KK[g]), .STRIDE(ST), .ADDR_W(32)
        ) dut (
            .clk(clk),
            .reset(rst[g]),
            .bus(b.slave)
        );
    end

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int oh_of(input int i);
        return (HH[i] - KK[i]) / ST + 1;
    endfunction

    function automatic int model(input int i, input int m, input int oa);
        int k = KK[i];
        int h = HH[i];
        int oh = oh_of(i);
        int ch = oa / (oh * oh);
        int r = (oa / oh) % oh;
        int c = oa % oh;
        int mx = -8;
        int s = 0;
        int res;
        for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
                int v = img[i][ch * h * h + (r * ST + ky) * h + c * ST + kx];
                if (v > mx) mx = v;
                s += v;
            end
        res = s / (k * k);
        if (s % (k * k) != 0 && s < 0) res = res - 1;
        if (m[0] == 1'b0) res = mx;
        if (m[1] == 1'b1 && res < 0) res = 0;
        return res;
    endfunction

    task automatic wr(input int i, input int a, input int v);
        in_we[i] = 1'b1;
        in_addr[i] = a;
        in_data[i] = 4'(v);
        img[i][a] = v;
        cyc(1);
        in_we[i] = 1'b0;
    endtask

    task automatic load(input int i);
        int h = HH[i];
        for (int c = 0; c < CC[i]; c++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < h; x++)
                    wr(i, (c * h + y) * h + x, ((c + y + x) % 16) - 8);
    endtask

    task automatic go(input int i, input int m);
        start[i] = 1'b1;
        mode[i] = 2'(m);
        cyc(1);
        start[i] = 1'b0;
        chk($sformatf("dut%0d busy after start", i), busy[i], 1);
        chk($sformatf("dut%0d done cleared by start", i), done[i], 0);
    endtask

    task automatic wait_done(input int i, input int want);
        int got = -1;
        for (int n = 1; n <= want + 50; n++) begin
            @(posedge clk);
            #1;
            if (done[i]) begin
                got = n;
                break;
            end
        end
        chk($sformatf("dut%0d done latency", i), got, want);
        chk($sformatf("dut%0d busy at done", i), busy[i], 0);
    endtask

    task automatic rd(input int i, input int a, input int e);
        read_addr[i] = a;
        rv[i] = 1'b1;
        q[i].push_back(e);
        cyc(1);
        rv[i] = 1'b0;
    endtask

    task automatic readback(input int i, input int m);
        int oh = oh_of(i);
        for (int oa = 0; oa < CC[i] * oh * oh; oa++) rd(i, oa, model(i, m, oa));
    endtask

    always @(posedge clk)
        for (int i = 0; i < NI; i++) rv_d[i] <= rv[i];

    always @(negedge clk)
        for (int i = 0; i < NI; i++)
            if (rv_d[i]) begin
                if (q[i].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut%0d read: got %0d, want nothing queued", i, rdat[i]);
                end else chk($sformatf("dut%0d read", i), rdat[i], q[i].pop_front());
            end

    task automatic seq0();
        load(0);
        go(0, 0);
        cyc(100);
        start[0] = 1'b1;
        in_we[0] = 1'b1;
        in_addr[0] = 0;
        in_data[0] = 4'sd7;
        cyc(1);
        start[0] = 1'b0;
        in_we[0] = 1'b0;
        chk("dut0 busy mid-pass", busy[0], 1);
        wait_done(0, 4096 * 7 - 101);
        rd(0, 0, -6);
        readback(0, 0);
        rd(0, 4096, 0);
    endtask

    task automatic seq1();
        load(1);
        go(1, 0);
        wait_done(1, 18 * 19);
        rd(1, 0, -2);
        readback(1, 0);
        go(1, 1);
        wait_done(1, 18 * 19);
        rd(1, 0, -5);
        readback(1, 1);
    endtask

    task automatic seq2();
        load(2);
        wr(2, 0, -3); wr(2, 1, -2); wr(2, 4, -2); wr(2, 5, -1);
        wr(2, 2, -1); wr(2, 3, 0); wr(2, 6, 0); wr(2, 7, 0);
        wr(2, 8, 5); wr(2, 9, -3); wr(2, 12, 2); wr(2, 13, 1);
        start[2] = 1'b1;
        mode[2] = 2'b01;
        in_we[2] = 1'b1;
        in_addr[2] = 0;
        in_data[2] = 4'sd7;
        cyc(1);
        start[2] = 1'b0;
        in_we[2] = 1'b0;
        chk("dut2 busy on start with write", busy[2], 1);
        wait_done(2, 56);
        rd(2, 0, -2); rd(2, 1, -1); rd(2, 2, 1);
        readback(2, 1);
        go(2, 3);
        wait_done(2, 56);
        rd(2, 0, 0); rd(2, 2, 1);
        readback(2, 3);
        go(2, 2);
        wait_done(2, 56);
        rd(2, 0, 0); rd(2, 2, 5);
        readback(2, 2);
        go(2, 0);
        wait_done(2, 56);
        rd(2, 0, -1);
        readback(2, 0);
        read_addr[2] = 2;
        go(2, 0);
        cyc(27);
        chk("dut2 busy before reset", busy[2], 1);
        rst[2] = 1'b1;
        #1;
        chk("dut2 busy in reset", busy[2], 0);
        chk("dut2 done in reset", done[2], 0);
        chk("dut2 read_data in reset", rdat[2], 0);
        cyc(2);
        rst[2] = 1'b0;
        go(2, 1);
        wait_done(2, 56);
        readback(2, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1;
            start[i] = 1'b0;
            mode[i] = 2'b00;
            in_we[i] = 1'b0;
            in_addr[i] = 0;
            in_data[i] = 0;
            read_addr[i] = 0;
            rv[i] = 1'b0;
        end
        cyc(3);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("dut%0d reset busy", i), busy[i], 0);
            chk($sformatf("dut%0d reset done", i), done[i], 0);
            chk($sformatf("dut%0d reset read_data", i), rdat[i], 0);
            rst[i] = 1'b0;
        end
        fork
            seq0();
            seq1();
            seq2();
        join
        cyc(3);
        for (int i = 0; i < NI; i++) chk($sformatf("dut%0d scoreboard drained", i), q[i].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
